// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single-port instruction memory between the fetch stage and the
// program loader. After reset the design sits in BOOT: fetch is stalled and
// only the loader may access memory. A load_done pulse moves it to RUN, where
// fetch has priority. A starvation counter force-grants the loader once it
// has been refused STARVE_LIM cycles in a row.
module imem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_LIM = 8,
  parameter bit BOOT_SKIP  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  // fetch requester (read-only)
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              stall_fetch,
  // loader requester (read/write)
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  input  logic              load_done,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // status
  output logic              mode_run,
  output logic              align_err
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = BOOT_SKIP ? ST_RUN : ST_BOOT;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] starve_reg, starve_next;
  logic             align_err_reg, align_err_next;
  logic [31:0]      sel_addr;
  logic             force_loader;

  // Bits above the memory window are deliberately dropped (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2]};

  // State, starvation counter and sticky alignment flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= RESET_STATE;
      starve_reg    <= '0;
      align_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      align_err_reg <= align_err_next;
    end
  end

  assign force_loader = (state_reg == ST_RUN) && l_req && (starve_reg == CNT_LIM);

  // Grant decision, next state and starvation counter update.
  always_comb begin
    f_gnt       = 1'b0;
    l_gnt       = 1'b0;
    stall_fetch = 1'b1;
    state_next  = state_reg;
    starve_next = '0;
    case (state_reg)
      ST_BOOT: begin
        // Fetch stays stalled; the loader owns the memory while the image is written.
        l_gnt = l_req;
        if (load_done) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (force_loader) begin
          l_gnt = 1'b1;
          f_gnt = 1'b0;
        end else begin
          f_gnt = f_req;
          l_gnt = l_req & ~f_req;
        end
        stall_fetch = f_req & ~f_gnt;
        if (l_req && !l_gnt) begin
          starve_next = (starve_reg == CNT_LIM) ? CNT_LIM : starve_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Memory drive: a single grant selects the address; writes come only from the loader.
  always_comb begin
    sel_addr  = l_gnt ? l_addr : f_addr;
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = sel_addr[ADDR_W+1:2];
    mem_wdata = l_wdata;
  end

  // Misaligned granted accesses set the flag; the access still proceeds truncated.
  always_comb begin
    align_err_next = align_err_reg
                   | (f_gnt & (f_addr[1:0] != 2'b00))
                   | (l_gnt & (l_addr[1:0] != 2'b00));
  end

  // Read-return channels: index 0 is fetch, index 1 is the loader.
  logic [1:0]  rd_issue;
  logic [1:0]  rvalid_all;
  logic [31:0] rdata_all [2];

  assign rd_issue[0] = f_gnt;
  assign rd_issue[1] = l_gnt & ~l_we;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_ret
      logic        rvalid_reg;
      logic [31:0] hold_reg;

      // Data arrives one cycle after the grant; keep the last word for the requester.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rvalid_reg <= 1'b0;
          hold_reg   <= '0;
        end else begin
          rvalid_reg <= rd_issue[gi];
          if (rvalid_reg) begin
            hold_reg <= mem_rdata;
          end
        end
      end

      assign rvalid_all[gi] = rvalid_reg;
      assign rdata_all[gi]  = rvalid_reg ? mem_rdata : hold_reg;
    end
  endgenerate

  assign f_rvalid  = rvalid_all[0];
  assign f_rdata   = rdata_all[0];
  assign l_rvalid  = rvalid_all[1];
  assign l_rdata   = rdata_all[1];
  assign mode_run  = (state_reg == ST_RUN);
  assign align_err = align_err_reg;

endmodule
